// File: rtl/axis_pkt_shaper_pkg.sv
// Shared types and sizing helpers for the AXI-Stream token-bucket shaper.
package axis_pkt_shaper_pkg;

  typedef enum logic {MODE_PKT = 1'b0, MODE_BEAT = 1'b1} shaper_mode_t;
  typedef enum logic {S_IDLE = 1'b0, S_IN_PKT = 1'b1} state_t;

  // Whole bits of the credit register, sign included.
  function automatic int credit_w(input int mtu, input int burst_w);
    return ((mtu > burst_w) ? mtu : burst_w) + 2;
  endfunction

endpackage

// File: rtl/axis_shaper_credit.sv
// Saturating signed fixed-point credit accumulator: +rate per clock, -1.0 per beat,
// clamped to [-(2**MTU), burst] whole beats.
module axis_shaper_credit
  import axis_pkt_shaper_pkg::*;
#(
  parameter int RATE_W  = 16,
  parameter int BURST_W = 8,
  parameter int MTU     = 10,
  parameter int CRED_W  = credit_w(MTU, BURST_W) + RATE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [RATE_W-1:0]        i_rate,
  input  logic [BURST_W-1:0]       i_burst,
  input  logic                     i_xfer,
  output logic signed [CRED_W-1:0] o_credit,
  output logic                     o_neg
);

  localparam logic signed [CRED_W-1:0] C_ZERO = '0;
  localparam logic signed [CRED_W-1:0] C_ONE  = CRED_W'(1) << RATE_W;
  localparam logic signed [CRED_W-1:0] C_LO   = -(CRED_W'(1) << (MTU + RATE_W));

  logic signed [CRED_W-1:0] r_credit;
  logic signed [CRED_W-1:0] w_rate;
  logic signed [CRED_W-1:0] w_hi;
  logic signed [CRED_W-1:0] w_sum;

  // The whole-bit headroom guarantees w_sum cannot wrap before saturation.
  assign w_rate = {{(CRED_W-RATE_W){1'b0}}, i_rate};
  assign w_hi   = {{(CRED_W-BURST_W-RATE_W){1'b0}}, i_burst, {RATE_W{1'b0}}};
  assign w_sum  = r_credit + w_rate - (i_xfer ? C_ONE : C_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_credit <= '0;
    else if (!i_en)         r_credit <= '0;
    else if (w_sum > w_hi)  r_credit <= w_hi;
    else if (w_sum < C_LO)  r_credit <= C_LO;
    else                    r_credit <= w_sum;
  end

  assign o_credit = r_credit;
  assign o_neg    = r_credit[CRED_W-1];

endmodule

// File: rtl/axis_pkt_shaper.sv
// AXI-Stream token-bucket rate shaper, zero-latency pass-through with packet or beat gating.
module axis_pkt_shaper
  import axis_pkt_shaper_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int RATE_W  = 16,
  parameter int BURST_W = 8,
  parameter int MTU     = 10,
  parameter int CNT_W   = 32,
  parameter int CRED_W  = credit_w(MTU, BURST_W) + RATE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic [RATE_W-1:0]        rate,
  input  logic [BURST_W-1:0]       burst,
  input  logic                     stat_clear,
  output logic [CNT_W-1:0]         stall_count,
  input  logic [DATA_W-1:0]        i_tdata,
  input  logic                     i_tlast,
  input  logic                     i_tvalid,
  output logic                     i_tready,
  output logic [DATA_W-1:0]        o_tdata,
  output logic                     o_tlast,
  output logic                     o_tvalid,
  input  logic                     o_tready,
  output state_t                   o_dbg_state,
  output logic signed [CRED_W-1:0] o_dbg_credit
);

  state_t           r_state;
  state_t           w_state_nxt;
  shaper_mode_t     r_mode;
  logic [CNT_W-1:0] r_stall;
  logic             w_gate;
  logic             w_xfer;
  logic             w_neg;

  // Handshake: a beat moves when i_tvalid & o_tready & ~gate. gate depends only on
  // registers and en, so i_tready never depends on i_tvalid.
  assign w_gate   = en & w_neg & ((r_state == S_IDLE) | (r_mode == MODE_BEAT));
  assign w_xfer   = i_tvalid & o_tready & ~w_gate;
  assign o_tdata  = i_tdata;
  assign o_tlast  = i_tlast;
  assign o_tvalid = i_tvalid & ~w_gate;
  assign i_tready = o_tready & ~w_gate;

  axis_shaper_credit #(
    .RATE_W  (RATE_W),
    .BURST_W (BURST_W),
    .MTU     (MTU),
    .CRED_W  (CRED_W)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .i_en     (en),
    .i_rate   (rate),
    .i_burst  (burst),
    .i_xfer   (w_xfer),
    .o_credit (o_dbg_credit),
    .o_neg    (w_neg)
  );

  // Mode only changes between packets so a packet is shaped under one policy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_PKT;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) r_mode <= shaper_mode_t'(mode);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer & ~i_tlast) w_state_nxt = S_IN_PKT;
      S_IN_PKT: if (w_xfer & i_tlast)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_stall <= '0;
    else if (stat_clear)                       r_stall <= '0;
    else if (i_tvalid & w_gate & ~(&r_stall))  r_stall <= r_stall + CNT_W'(1);
  end

  assign stall_count = r_stall;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axis_pkt_shaper.sv
// Randomized bench for axis_pkt_shaper against a token-bucket reference model.
module tb_axis_pkt_shaper;
  import axis_pkt_shaper_pkg::*;

  localparam int DATA_W  = 64;
  localparam int RATE_W  = 16;
  localparam int BURST_W = 8;
  localparam int MTU     = 10;
  localparam int CNT_W   = 8;
  localparam int CRED_W  = credit_w(MTU, BURST_W) + RATE_W;
  localparam longint ONE_BEAT  = longint'(1) << RATE_W;
  localparam longint CRED_LO   = -(longint'(1) << (MTU + RATE_W));
  localparam int     STALL_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, en, mode, stat_clear;
  logic [RATE_W-1:0]  rate;
  logic [BURST_W-1:0] burst;
  logic [CNT_W-1:0]   stall_count;
  logic [DATA_W-1:0]  i_tdata, o_tdata;
  logic i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
  state_t dbg_state;
  logic signed [CRED_W-1:0] dbg_credit;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: credit in units of 2**-RATE_W beats
  longint m_credit;
  bit     m_in_pkt;
  bit     m_mode_l;
  int     m_stall;
  logic [DATA_W:0] exp_q[$];

  bit drv_pend;
  int drv_beat, drv_len, drv_lmin, drv_lmax;
  int sop_q[$];
  int xfer_q[$];

  axis_pkt_shaper #(
    .DATA_W(DATA_W), .RATE_W(RATE_W), .BURST_W(BURST_W), .MTU(MTU), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rate(rate), .burst(burst),
    .stat_clear(stat_clear), .stall_count(stall_count),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_dbg_state(dbg_state), .o_dbg_credit(dbg_credit)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_in_pkt = 1'b0;
    m_mode_l = 1'b0;
    m_stall  = 0;
    exp_q.delete();
    drv_pend = 1'b0;
    drv_beat = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stat_clear = 1'b0;
    i_tvalid = 1'($urandom_range(1));
    i_tlast = 1'b0;
    o_tready = 1'($urandom_range(1));
    i_tdata = {$urandom, $urandom};
    model_reset();
    @(negedge clk);
    chk("rst_tvalid", o_tvalid, i_tvalid);
    chk("rst_tready", i_tready, o_tready);
    chk("rst_stall", stall_count, 0);
    chk("rst_credit", longint'(dbg_credit), 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_tvalid = 1'b0;
  endtask

  // One clock: check outputs at the negedge against the model, then advance it.
  task automatic step(output bit xf);
    bit g, mx, nin, nmode;
    longint nc, hi;
    int ns;
    logic [DATA_W:0] exp_v;
    @(negedge clk);
    g  = en && (m_credit < 0) && (!m_in_pkt || m_mode_l);
    chk("o_tvalid", o_tvalid, i_tvalid && !g);
    chk("i_tready", i_tready, o_tready && !g);
    chk("o_tdata", {o_tlast, o_tdata}, {i_tlast, i_tdata});
    chk("stall_count", stall_count, m_stall);
    chk("credit", longint'(dbg_credit), m_credit);
    chk("state", dbg_state, m_in_pkt);
    mx = i_tvalid && o_tready && !g;
    if (mx) exp_q.push_back({i_tlast, i_tdata});
    xf = o_tvalid && o_tready;
    if (xf) begin
      if (exp_q.size() != 0) exp_v = exp_q.pop_front();
      else exp_v = 'x;
      chk("beat", {o_tlast, o_tdata}, exp_v);
      xfer_q.push_back(cyc);
    end
    hi = longint'(burst) << RATE_W;
    nc = m_credit + longint'(rate) - (mx ? ONE_BEAT : 0);
    if (nc > hi) nc = hi;
    if (nc < CRED_LO) nc = CRED_LO;
    if (!en) nc = 0;
    nmode = m_in_pkt ? m_mode_l : mode;
    nin   = mx ? !i_tlast : m_in_pkt;
    if (stat_clear) ns = 0;
    else if (i_tvalid && g && m_stall < STALL_MAX) ns = m_stall + 1;
    else ns = m_stall;
    @(posedge clk);
    #1;
    m_credit = nc;
    m_mode_l = nmode;
    m_in_pkt = nin;
    m_stall  = ns;
    cyc++;
  endtask

  task automatic set_len(input int lmin, input int lmax);
    drv_lmin = lmin;
    drv_lmax = lmax;
    if (drv_beat == 0 && !drv_pend) drv_len = $urandom_range(lmax, lmin);
  endtask

  task automatic run_stream(input int cycles, input int vpct, input int rpct);
    bit xf;
    for (int c = 0; c < cycles; c++) begin
      if (!drv_pend) begin
        i_tvalid = ($urandom_range(99) < vpct);
        if (i_tvalid) begin
          drv_pend = 1'b1;
          i_tdata  = {$urandom, $urandom};
          i_tlast  = (drv_beat == drv_len - 1);
        end
      end
      o_tready = ($urandom_range(99) < rpct);
      step(xf);
      if (xf) begin
        if (drv_beat == 0) sop_q.push_back(cyc);
        drv_pend = 1'b0;
        if (i_tlast) begin
          drv_beat = 0;
          drv_len  = $urandom_range(drv_lmax, drv_lmin);
        end else begin
          drv_beat++;
        end
      end
    end
  endtask

  task automatic cfg(input bit e, input bit m, input int r, input int b);
    en = e;
    mode = m;
    rate = RATE_W'(r);
    burst = BURST_W'(b);
  endtask

  initial begin
    cfg(1, 0, 0, 0);
    // Packet mode at 0.25: 4-beat packets, SOP every 16 clocks, 12 stalls each
    do_reset();
    cfg(1, 0, 'h4000, 0);
    set_len(4, 4);
    sop_q.delete();
    run_stream(50, 100, 100);
    chk("s1_sop_count", sop_q.size(), 4);
    for (int i = 1; i < sop_q.size(); i++) chk("s1_sop_gap", sop_q[i] - sop_q[i-1], 16);
    chk("s1_stall", stall_count, 36);

    // Beat mode at 0.5: every other clock, even inside the packet
    do_reset();
    cfg(1, 1, 'h8000, 0);
    run_stream(1, 0, 100);
    set_len(8, 8);
    xfer_q.delete();
    run_stream(16, 100, 100);
    chk("s2_xfer_count", xfer_q.size(), 8);
    for (int i = 1; i < xfer_q.size(); i++) chk("s2_xfer_gap", xfer_q[i] - xfer_q[i-1], 2);

    // Burst cap 8.0 then a 12-beat packet: contiguous, -1.0 left, 4 gated clocks
    do_reset();
    cfg(1, 0, 'h4000, 8);
    run_stream(64, 0, 100);
    chk("s3_cap", longint'(dbg_credit), longint'(8) << RATE_W);
    set_len(12, 12);
    xfer_q.delete();
    run_stream(17, 100, 100);
    chk("s3_xfer_count", xfer_q.size(), 13);
    for (int i = 1; i < 12; i++) chk("s3_contig", xfer_q[i] - xfer_q[i-1], 1);
    if (xfer_q.size() == 13) chk("s3_next_sop", xfer_q[12] - xfer_q[11], 5);
    run_stream(40, 0, 100);
    burst = BURST_W'(2);
    run_stream(1, 0, 100);
    chk("s3_clamp", longint'(dbg_credit), longint'(2) << RATE_W);

    // rate=0: first packet free, then gated forever; stall counter saturates and clears
    do_reset();
    cfg(1, 0, 0, 0);
    run_stream(1, 0, 100);
    set_len(3, 3);
    run_stream(103, 100, 100);
    chk("s4_stall_lin", stall_count, 100);
    run_stream(200, 100, 100);
    chk("s4_stall_sat", stall_count, STALL_MAX);
    stat_clear = 1'b1;
    run_stream(1, 100, 100);
    stat_clear = 1'b0;
    chk("s4_clear", stall_count, 0);
    run_stream(1, 100, 100);
    chk("s4_after_clear", stall_count, 1);

    // Bypass, then a mode change mid-packet that waits for tlast
    do_reset();
    cfg(0, 0, 0, 0);
    set_len(1, 6);
    run_stream(200, 70, 70);
    chk("s5_bypass_stall", stall_count, 0);
    do_reset();
    cfg(1, 0, 'h4000, 0);
    run_stream(1, 0, 100);
    set_len(6, 6);
    xfer_q.delete();
    run_stream(2, 100, 100);
    mode = 1'b1;
    run_stream(4, 100, 100);
    chk("s5_pkt_beats", xfer_q.size(), 6);
    for (int i = 1; i < xfer_q.size(); i++) chk("s5_contig", xfer_q[i] - xfer_q[i-1], 1);
    run_stream(60, 100, 100);

    // Asynchronous reset while gated mid-packet
    do_reset();
    cfg(1, 1, 'h8000, 0);
    run_stream(1, 0, 100);
    set_len(8, 8);
    run_stream(3, 100, 100);
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    #1;
    chk("s6_gated", o_tvalid, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("s6_async_tvalid", o_tvalid, i_tvalid);
    chk("s6_async_tready", i_tready, o_tready);
    chk("s6_async_credit", longint'(dbg_credit), 0);
    chk("s6_async_stall", stall_count, 0);
    chk("s6_async_state", dbg_state, 0);
    do_reset();
    set_len(1, 8);
    run_stream(40, 80, 80);

    // Oversize packet at rate 0 drives credit into the low clamp
    do_reset();
    cfg(1, 0, 0, 0);
    run_stream(1, 0, 100);
    set_len(1100, 1100);
    run_stream(1100, 100, 100);
    chk("lo_sat", longint'(dbg_credit), CRED_LO);

    // Random configuration blocks
    do_reset();
    set_len(1, 8);
    for (int blk = 0; blk < 30; blk++) begin
      cfg(($urandom_range(9) != 0), 1'($urandom_range(1)),
          ($urandom_range(2) == 0) ? int'($urandom_range(65535)) : int'($urandom_range(16'h6000, 16'h0400)),
          $urandom_range(20));
      stat_clear = ($urandom_range(4) == 0);
      run_stream(1, 80, 80);
      stat_clear = 1'b0;
      run_stream(49, $urandom_range(100, 50), $urandom_range(100, 50));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_pkt_shaper.md
Name: axis_pkt_shaper

Overview:
AXI-Stream token-bucket rate shaper with zero-latency pass-through. A signed fixed-point credit accumulator gains a programmable fractional rate every clock, up to a burst cap, and loses 1.0 per transferred beat.
- Packet mode gates only between packets. Packets stay contiguous and stall only before SOP.
- Beat mode gates any beat.
- A saturating stall-cycle counter supports debug.
- Sits in front of Ethernet/CHDR egress paths, next to the existing packet throttles.

Parameters:
DATA_W, 64, AXI-Stream tdata width in bits
RATE_W, 16, rate width; rate is UQ0.RATE_W beats per clock
BURST_W, 8, burst cap width; cap is a whole number of beats, max 2**BURST_W-1
MTU, 10, maximum packet length is 2**MTU beats
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
en  in  1  0 = bypass (no gating, credit forced to 0)
mode  in  1  0 = packet mode, 1 = beat mode; sampled only while IDLE
rate  in  RATE_W  credit added per clock, UQ0.RATE_W; sampled every clock
burst  in  BURST_W  credit ceiling in whole beats; sampled every clock
stat_clear  in  1  synchronous clear of stall_count
stall_count  out  CNT_W  cycles with i_tvalid=1 and gate=1, saturating
i_tdata  in  DATA_W  input data
i_tlast  in  1  input end of packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  DATA_W  equals i_tdata
o_tlast  out  1  equals i_tlast
o_tvalid  out  1  i_tvalid & ~gate
o_tready  in  1  output ready

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values: credit=0, state=IDLE, latched mode=0, gate=0, stall_count=0.
  - Outputs follow reset immediately: o_tvalid=i_tvalid, i_tready=o_tready.
- Data path is combinational, 0 latency. gate is a function of registered state only, so there is no path from valid to ready.
- xfer = i_tvalid & o_tready & ~gate.
- Credit register:
  - Signed, RATE_W fractional bits, max(MTU,BURST_W)+2 whole bits including sign.
  - next = credit + rate - (xfer ? 1.0 : 0).
  - Saturate high at burst<<RATE_W and low at -(2**MTU)<<RATE_W.
  - If burst is lowered below the current credit, clamp on the next clock.
- State machine, 2 states:
  - IDLE --xfer & ~i_tlast--> IN_PKT.
  - IN_PKT --xfer & i_tlast--> IDLE.
  - A single-beat packet stays in IDLE.
  - mode is latched on every IDLE clock and held while IN_PKT.
- Gate rules:
  - Packet mode: gate = (state==IDLE) & credit<0. Never gate in IN_PKT; credit may go negative mid-packet.
  - Beat mode: gate = credit<0 in any state.
  - en=0: gate=0 and credit<=0 every clock; the state machine still tracks packets.
- Credit deficit: a packet of L beats at rate r leaves credit = c0 + L*r - L. The next SOP waits until credit>=0, giving gap = ceil((L - L*r - c0)/r) cycles.
- rate=0 with negative credit gates indefinitely. This is legal and needs no recovery beyond a nonzero rate or en=0.
- stall_count:
  - +1 when i_tvalid & gate & en.
  - Saturates at all-ones.
  - stat_clear has priority over increment; cleared value is 0 on the next clock.
- Reset mid-packet returns to IDLE with credit 0. The downstream packet is truncated; this is the caller's responsibility.

Decomposition:
- Package axis_pkt_shaper_pkg:
  - shaper_mode_t enum {MODE_PKT, MODE_BEAT}
  - state_t enum {S_IDLE, S_IN_PKT}
  - function credit_w(MTU, BURST_W) returning the whole-bit width
- Sub-module axis_shaper_credit: the saturating signed fixed-point accumulator.
  - Inputs: rate, burst, xfer, en.
  - Output: credit, negative flag.
- The top holds the state machine, gating and stall counter.

Test Plan:
- Packet mode, rate=0x4000 (0.25), burst=0, 4-beat packets, always valid/ready -> each packet contiguous, credit -3.0 after tlast, 12 gated cycles, SOP every 16 cycles; stall_count +12 per packet.
- Beat mode, rate=0x8000 (0.5), burst=0, continuous 8-beat packet -> beats on alternate cycles, including mid-packet gaps; o_tvalid toggles 1,0,1,0.
- Packet mode, rate=0x4000, burst=8, 64 idle cycles, then a 12-beat packet -> credit saturates at 8.0; packet passes contiguously; credit -1.0 at end; 4 gated cycles before next SOP.
- rate=0, packet mode, 3-beat packet then continuous valid -> first packet passes (credit 0), then gated forever; stall_count increments each cycle; stat_clear pulse -> 0 next clock.
- en=0 with rate=0 -> o_tvalid=i_tvalid and i_tready=o_tready every cycle; stall_count stays 0. Toggling mode mid-packet takes effect only after tlast.
- rst asserted asynchronously mid-packet while gated -> o_tvalid=i_tvalid immediately, without waiting for a clock; after release, state=IDLE, credit=0, stall_count=0.
